// File: rtl/slave_read_addr_arbiter_if.sv
// AR-side arbitration bus for one crossbar slave port.
// The "master" modport is the arbiter itself (it drives grant and return
// routing); the "slave" modport is the surrounding crossbar fabric.
interface slave_read_addr_arbiter_if #(
   parameter int masters = 2,
   parameter int slaves  = 2
);
   localparam int MW = (masters > 1) ? $clog2(masters) : 1;
   localparam int SW = (slaves  > 1) ? $clog2(slaves)  : 1;

   logic          master_read_addr_fifo_empty  [0:masters-1];
   logic [SW-1:0] read_addr_forward_dest_slave [0:masters-1];
   logic          slave_read_addr_fifo_full;
   logic          rlast_accepted;
   logic [MW:0]   grant_master_number;
   logic          push_to_fifo;
   logic [MW-1:0] read_data_return_dest_master;
   logic          return_valid;

   modport master (
      input  master_read_addr_fifo_empty, read_addr_forward_dest_slave,
             slave_read_addr_fifo_full, rlast_accepted,
      output grant_master_number, push_to_fifo,
             read_data_return_dest_master, return_valid
   );

   modport slave (
      output master_read_addr_fifo_empty, read_addr_forward_dest_slave,
             slave_read_addr_fifo_full, rlast_accepted,
      input  grant_master_number, push_to_fifo,
             read_data_return_dest_master, return_valid
   );
endinterface

// File: rtl/slave_read_addr_arbiter.sv
// Read-address arbiter for one crossbar slave port. Picks a requesting
// master, hands its AR head to the slave AR FIFO, and remembers grant order
// so R bursts can be routed back to their owners.
// Optional: define XBAR_AR_FIXED_PRIORITY_EN for fixed lowest-index-wins
// priority instead of the default round-robin.
module slave_read_addr_arbiter #(
   parameter int masters           = 2,
   parameter int slaves            = 2,
   parameter int i_am_slave_number = 0,
   parameter int pending_depth     = 8
) (
   input  logic ACLK,
   input  logic ARESETn,
   slave_read_addr_arbiter_if.master bus
);
   localparam int MW = (masters > 1) ? $clog2(masters) : 1;
   localparam int SW = (slaves  > 1) ? $clog2(slaves)  : 1;
   localparam int PW = (pending_depth > 1) ? $clog2(pending_depth) : 1;
   localparam int CW = $clog2(pending_depth) + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [MW-1:0]   grant_q;
   logic [MW-1:0]   sel;
   logic            any_req;
   logic            load_grant;
   logic            transfer;
   logic [masters-1:0] req;

   logic [MW-1:0]   order_mem [pending_depth];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count_q;
   logic            do_pop;

`ifndef XBAR_AR_FIXED_PRIORITY_EN
   logic [MW-1:0]   rr_ptr;
`endif

   // a master requests when its AR head is present and decodes to this slave
   always_comb begin
      req = '0;
      for (int m = 0; m < masters; m++)
         req[m] = !bus.master_read_addr_fifo_empty[m] &&
                  (bus.read_addr_forward_dest_slave[m] == SW'(i_am_slave_number));
   end

   // pick the next master to grant
   always_comb begin
      sel     = '0;
      any_req = 1'b0;
`ifdef XBAR_AR_FIXED_PRIORITY_EN
      for (int m = masters - 1; m >= 0; m--)
         if (req[m]) begin
            sel     = MW'(m);
            any_req = 1'b1;
         end
`else
      for (int k = 0; k < masters; k++) begin
         int idx;
         idx = int'(rr_ptr) + k;
         if (idx >= masters) idx = idx - masters;
         if (!any_req && req[idx]) begin
            sel     = MW'(idx);
            any_req = 1'b1;
         end
      end
`endif
   end

   // FSM next state and grant outputs; one bubble cycle after each grant
   always_comb begin
      state_d                 = state_q;
      load_grant              = 1'b0;
      transfer                = 1'b0;
      bus.grant_master_number = '1;
      bus.push_to_fifo        = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req && (count_q < CW'(pending_depth))) begin
               state_d    = GRANT;
               load_grant = 1'b1;
            end
         end
         GRANT: begin
            bus.grant_master_number = {1'b0, grant_q};
            bus.push_to_fifo        = 1'b1;
            if (!req[grant_q])
               state_d = IDLE;
            else if (!bus.slave_read_addr_fifo_full) begin
               transfer = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, grant register and round-robin pointer
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         grant_q <= '0;
`ifndef XBAR_AR_FIXED_PRIORITY_EN
         rr_ptr  <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (load_grant) grant_q <= sel;
`ifndef XBAR_AR_FIXED_PRIORITY_EN
         if (transfer)
            rr_ptr <= (grant_q == MW'(masters - 1)) ? '0 : grant_q + 1'b1;
`endif
      end
   end

   assign do_pop = bus.rlast_accepted && (count_q != '0);

   // order FIFO pointers and occupancy; pop on empty is ignored
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (transfer)
            wr_ptr <= (wr_ptr == PW'(pending_depth - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == PW'(pending_depth - 1)) ? '0 : rd_ptr + 1'b1;
         case ({transfer, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // order FIFO storage; contents need no reset since occupancy gates reads
   always_ff @(posedge ACLK) begin
      if (ARESETn && transfer) order_mem[wr_ptr] <= grant_q;
   end

   assign bus.return_valid                 = (count_q != '0);
   assign bus.read_data_return_dest_master = (count_q != '0) ? order_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_slave_read_addr_arbiter.sv
// Scoreboard bench for slave_read_addr_arbiter (slave 0, two masters,
// pending_depth 8). Expected grants and return destinations are queued by
// the stimulus; a negedge monitor pops and compares them.
module tb_slave_read_addr_arbiter;
   logic ACLK = 1'b0;
   logic ARESETn;
   int   vecs = 0;
   int   bad  = 0;
   int   exp_grant[$];
   int   exp_ret[$];

   slave_read_addr_arbiter_if #(.masters(2), .slaves(2)) bus ();

   slave_read_addr_arbiter #(
      .masters(2), .slaves(2), .i_am_slave_number(0), .pending_depth(8)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   task automatic set_req(input logic m0, input logic m1);
      bus.master_read_addr_fifo_empty[0] = !m0;
      bus.master_read_addr_fifo_empty[1] = !m1;
   endtask

   // one complete grant+transfer for a single requesting master, from IDLE
   task automatic do_grant(input int m);
      exp_grant.push_back(m);
      set_req(m == 0, m == 1);
      tick(2);
      set_req(1'b0, 1'b0);
   endtask

   // monitor: grants accepted by the slave FIFO and returns popped by RLAST
   initial begin
      forever begin
         int g;
         @(negedge ACLK);
         if (ARESETn === 1'b1) begin
            g = int'(bus.grant_master_number);
            if (bus.push_to_fifo === 1'b1 && bus.slave_read_addr_fifo_full === 1'b0 && g < 2 &&
                bus.master_read_addr_fifo_empty[g] === 1'b0 && bus.read_addr_forward_dest_slave[g] === 1'b0) begin
               if (exp_grant.size() == 0) chk("grant_unexpected", g, 32'hff);
               else chk("grant_order", g, exp_grant.pop_front());
            end
            if (bus.rlast_accepted === 1'b1) begin
               if (exp_ret.size() == 0) chk("return_unexpected", bus.read_data_return_dest_master, 32'hff);
               else chk("return_dest", bus.read_data_return_dest_master, exp_ret.pop_front());
               chk("return_valid_at_pop", bus.return_valid, 1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ARESETn = 1'b0;
      set_req(1'b0, 1'b0);
      bus.read_addr_forward_dest_slave[0] = 1'b0;
      bus.read_addr_forward_dest_slave[1] = 1'b0;
      bus.slave_read_addr_fifo_full = 1'b0;
      bus.rlast_accepted = 1'b0;
      tick(3);
      ARESETn = 1'b1;
      @(negedge ACLK);
      chk("rst_grant", bus.grant_master_number, 2'b11);
      chk("rst_push", bus.push_to_fifo, 0);
      chk("rst_return_valid", bus.return_valid, 0);
      chk("rst_return_dest", bus.read_data_return_dest_master, 0);

      // both masters request continuously: alternating (or fixed) grants
      tick(1);
`ifdef XBAR_AR_FIXED_PRIORITY_EN
      for (int i = 0; i < 4; i++) begin exp_grant.push_back(0); exp_ret.push_back(0); end
`else
      for (int i = 0; i < 4; i++) begin exp_grant.push_back(i % 2); exp_ret.push_back(i % 2); end
`endif
      set_req(1'b1, 1'b1);
      tick(8);
      set_req(1'b0, 1'b0);
      chk("four_grants_in_8_cycles", exp_grant.size(), 0);
      bus.rlast_accepted = 1'b1;
      tick(4);
      bus.rlast_accepted = 1'b0;
      @(negedge ACLK);
      chk("drained_after_rr", bus.return_valid, 0);

      // slave FIFO full holds the grant to master 1
      tick(1);
      bus.slave_read_addr_fifo_full = 1'b1;
      set_req(1'b0, 1'b1);
      tick(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         chk("hold_grant", bus.grant_master_number, 1);
         chk("hold_push", bus.push_to_fifo, 1);
         chk("hold_no_order_push", bus.return_valid, 0);
         tick(1);
      end
      exp_grant.push_back(1);
      bus.slave_read_addr_fifo_full = 1'b0;
      tick(1);
      set_req(1'b0, 1'b0);
      @(negedge ACLK);
      chk("after_hold_valid", bus.return_valid, 1);
      chk("after_hold_dest", bus.read_data_return_dest_master, 1);
      tick(1);
      exp_ret.push_back(1);
      bus.rlast_accepted = 1'b1;
      tick(1);
      bus.rlast_accepted = 1'b0;

      // eight outstanding bursts block further grants until one returns
      for (int i = 0; i < 8; i++) exp_grant.push_back(0);
      set_req(1'b1, 1'b0);
      tick(16);
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         chk("full_pending_idle", bus.grant_master_number, 2'b11);
         chk("full_pending_nopush", bus.push_to_fifo, 0);
         tick(1);
      end
      exp_ret.push_back(0);
      exp_grant.push_back(0);
      bus.rlast_accepted = 1'b1;
      tick(1);
      bus.rlast_accepted = 1'b0;
      @(negedge ACLK);
      chk("pop_cycle_still_idle", bus.grant_master_number, 2'b11);
      tick(1);
      @(negedge ACLK);
      chk("grant_after_pop", bus.grant_master_number, 0);
      tick(1);
      set_req(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) exp_ret.push_back(0);
      bus.rlast_accepted = 1'b1;
      tick(8);
      bus.rlast_accepted = 1'b0;
      @(negedge ACLK);
      chk("drained_after_full", bus.return_valid, 0);

      // return routing follows grant order 1,0,1
      tick(1);
      do_grant(1);
      do_grant(0);
      do_grant(1);
      exp_ret.push_back(1);
      exp_ret.push_back(0);
      exp_ret.push_back(1);
      bus.rlast_accepted = 1'b1;
      tick(3);
      bus.rlast_accepted = 1'b0;
      @(negedge ACLK);
      chk("drained_after_order", bus.return_valid, 0);

      // request for another slave is ignored
      tick(1);
      bus.read_addr_forward_dest_slave[0] = 1'b1;
      set_req(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         chk("other_slave_idle", bus.grant_master_number, 2'b11);
         chk("other_slave_nopush", bus.push_to_fifo, 0);
         tick(1);
      end
      set_req(1'b0, 1'b0);
      bus.read_addr_forward_dest_slave[0] = 1'b0;

      // reset during GRANT with two outstanding
      do_grant(0);
      do_grant(1);
      bus.slave_read_addr_fifo_full = 1'b1;
      set_req(1'b1, 1'b0);
      tick(1);
      @(negedge ACLK);
      chk("pre_reset_grant", bus.grant_master_number, 0);
      chk("pre_reset_valid", bus.return_valid, 1);
      tick(1);
      ARESETn = 1'b0;
      tick(1);
      ARESETn = 1'b1;
      set_req(1'b0, 1'b0);
      bus.slave_read_addr_fifo_full = 1'b0;
      @(negedge ACLK);
      chk("mid_rst_grant", bus.grant_master_number, 2'b11);
      chk("mid_rst_push", bus.push_to_fifo, 0);
      chk("mid_rst_valid", bus.return_valid, 0);
      chk("mid_rst_dest", bus.read_data_return_dest_master, 0);

      tick(2);
      chk("grant_queue_empty", exp_grant.size(), 0);
      chk("return_queue_empty", exp_ret.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end
endmodule
